// File: rtl/counter_pkg.sv
// Shared constants for counter_n_bits: MODO encodings and default geometry.
// Imported by the counter and by any wrapper that cascades several counters.
package counter_pkg;

    localparam int          DEFAULT_WIDTH    = 16;
    localparam int unsigned DEFAULT_DEC_STEP = 3;

    typedef enum logic [1:0] {
        MODO_UP        = 2'b00,
        MODO_DOWN      = 2'b01,
        MODO_DOWN_STEP = 2'b10,
        MODO_LOAD      = 2'b11
    } modo_t;

endpackage

// File: rtl/counter_n_bits.sv
// Up/down/step-down counter with parallel load, registered ripple-carry-out
// and a combinational terminal-count for synchronous TC->CI cascading.
module counter_n_bits
    import counter_pkg::*;
#(
    parameter int          WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned DEC_STEP = DEFAULT_DEC_STEP
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic             CI,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             TC
);

    // Step is reduced modulo 2^WIDTH so the wrap test and the subtraction agree.
    localparam logic [WIDTH-1:0] STEP = WIDTH'(DEC_STEP);

    logic [WIDTH-1:0] r_q;
    logic             r_rco;
    modo_t            w_modo;
    logic             w_wrap;
    logic             w_tc;

    assign w_modo = modo_t'(MODO);

    // Wrap condition for the selected mode, evaluated on the current count.
    always_comb begin
        w_wrap = 1'b0;
        case (w_modo)
            MODO_UP:        w_wrap = (r_q == {WIDTH{1'b1}});
            MODO_DOWN:      w_wrap = (r_q == '0);
            MODO_DOWN_STEP: w_wrap = (r_q < STEP);
            default:        w_wrap = 1'b0;
        endcase
    end

    // RESET is ANDed in first so TC is a clean 0 even while Q is still unknown.
    assign w_tc = ~RESET & ENB & CI & w_wrap;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q   <= '0;
            r_rco <= 1'b0;
        end else if (!ENB) begin
            r_rco <= 1'b0;
        end else begin
            r_rco <= w_tc;
            case (w_modo)
                MODO_UP:        if (CI) r_q <= r_q + WIDTH'(1);
                MODO_DOWN:      if (CI) r_q <= r_q - WIDTH'(1);
                MODO_DOWN_STEP: if (CI) r_q <= r_q - STEP;
                default:        r_q <= D;
            endcase
        end
    end

    assign Q   = r_q;
    assign RCO = r_rco;
    assign TC  = w_tc;

endmodule

// File: tb/tb_counter_n_bits.sv
// Directed bench for counter_n_bits: a 16-bit instance and a two-stage
// 4-bit cascade, with expected Q/RCO queued at drive time and checked after the edge.
module tb_counter_n_bits;
    import counter_pkg::*;

    typedef struct {
        string       tag;
        logic [15:0] q;
        logic        rco;
    } exp_t;

    exp_t sb[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    logic        clk = 1'b0;
    logic        rst, enb, ci;
    logic [1:0]  modo;
    logic [15:0] d;
    logic [15:0] q;
    logic        rco, tc;

    logic        c_rst, c_enb;
    logic [1:0]  c_modo;
    logic [7:0]  c_d;
    logic [3:0]  c_q_lo, c_q_hi;
    logic        c_rco_lo, c_rco_hi, c_tc_lo, c_tc_hi;

    always #5 clk = ~clk;

    counter_n_bits #(.WIDTH(16), .DEC_STEP(3)) dut (
        .CLK(clk), .RESET(rst), .ENB(enb), .MODO(modo), .CI(ci), .D(d),
        .Q(q), .RCO(rco), .TC(tc)
    );

    counter_n_bits #(.WIDTH(4), .DEC_STEP(3)) u_lo (
        .CLK(clk), .RESET(c_rst), .ENB(c_enb), .MODO(c_modo), .CI(1'b1), .D(c_d[3:0]),
        .Q(c_q_lo), .RCO(c_rco_lo), .TC(c_tc_lo)
    );

    counter_n_bits #(.WIDTH(4), .DEC_STEP(3)) u_hi (
        .CLK(clk), .RESET(c_rst), .ENB(c_enb), .MODO(c_modo), .CI(c_tc_lo), .D(c_d[7:4]),
        .Q(c_q_hi), .RCO(c_rco_hi), .TC(c_tc_hi)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    endtask

    // One clock of the 16-bit counter: TC checked before the edge, Q/RCO after it.
    task automatic cyc(input string tag, input logic i_rst, input logic i_enb,
                       input logic [1:0] i_modo, input logic i_ci, input logic [15:0] i_d,
                       input logic exp_tc, input logic [15:0] exp_q, input logic exp_rco);
        exp_t e;
        @(negedge clk);
        rst = i_rst; enb = i_enb; modo = i_modo; ci = i_ci; d = i_d;
        #1;
        check_bit({tag, ".tc"}, tc, exp_tc);
        e.tag = tag; e.q = exp_q; e.rco = exp_rco;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_word({e.tag, ".q"}, q, e.q);
        check_bit({e.tag, ".rco"}, rco, e.rco);
        $display("%-14s rst=%b enb=%b modo=%b ci=%b d=%04h -> q=%04h rco=%b tc_pre=%b",
                 tag, i_rst, i_enb, i_modo, i_ci, i_d, q, rco, exp_tc);
    endtask

    // One clock of the cascaded pair; observed value is the combined 8-bit count.
    task automatic ccyc(input string tag, input logic i_rst, input logic [1:0] i_modo,
                        input logic [7:0] i_d, input logic [7:0] exp_q, input logic exp_rco_hi);
        exp_t e;
        @(negedge clk);
        c_rst = i_rst; c_enb = 1'b1; c_modo = i_modo; c_d = i_d;
        e.tag = tag; e.q = {8'h00, exp_q}; e.rco = exp_rco_hi;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_word({e.tag, ".q"}, {8'h00, c_q_hi, c_q_lo}, e.q);
        check_bit({e.tag, ".rco_hi"}, c_rco_hi, e.rco);
        $display("%-14s modo=%b d=%02h -> q=%01h%01h rco_hi=%b",
                 tag, i_modo, i_d, c_q_hi, c_q_lo, c_rco_hi);
    endtask

    initial begin
        rst = 1'b1; enb = 1'b1; modo = MODO_UP; ci = 1'b1; d = 16'h0;
        c_rst = 1'b1; c_enb = 1'b1; c_modo = MODO_UP; c_d = 8'h00;

        //   tag             rst  enb  modo            ci    d         tc    q         rco
        cyc("reset",         1'b1, 1'b1, MODO_UP,        1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
        cyc("load_1234",     1'b0, 1'b1, MODO_LOAD,      1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0);
        cyc("up_1235",       1'b0, 1'b1, MODO_UP,        1'b1, 16'h0000, 1'b0, 16'h1235, 1'b0);
        cyc("rst_midcount",  1'b1, 1'b1, MODO_UP,        1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        cyc("resume_0001",   1'b0, 1'b1, MODO_UP,        1'b1, 16'h0000, 1'b0, 16'h0001, 1'b0);
        cyc("load_fffe",     1'b0, 1'b1, MODO_LOAD,      1'b1, 16'hFFFE, 1'b0, 16'hFFFE, 1'b0);
        cyc("up_ffff",       1'b0, 1'b1, MODO_UP,        1'b1, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
        cyc("hold_at_ffff",  1'b0, 1'b0, MODO_UP,        1'b1, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
        cyc("up_wrap",       1'b0, 1'b1, MODO_UP,        1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1);
        cyc("up_after_wrap", 1'b0, 1'b1, MODO_UP,        1'b1, 16'h0000, 1'b0, 16'h0001, 1'b0);
        cyc("load_0002",     1'b0, 1'b1, MODO_LOAD,      1'b1, 16'h0002, 1'b0, 16'h0002, 1'b0);
        cyc("step_wrap",     1'b0, 1'b1, MODO_DOWN_STEP, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
        cyc("load_0003",     1'b0, 1'b1, MODO_LOAD,      1'b1, 16'h0003, 1'b0, 16'h0003, 1'b0);
        cyc("step_to_zero",  1'b0, 1'b1, MODO_DOWN_STEP, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        cyc("load_00a5",     1'b0, 1'b1, MODO_LOAD,      1'b1, 16'h00A5, 1'b0, 16'h00A5, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc("enb0_hold",  1'b0, 1'b0, MODO_UP,        1'b1, 16'h1111, 1'b0, 16'h00A5, 1'b0);
        cyc("ci0_down_hold", 1'b0, 1'b1, MODO_DOWN,      1'b0, 16'h0000, 1'b0, 16'h00A5, 1'b0);
        cyc("load_ci0",      1'b0, 1'b1, MODO_LOAD,      1'b0, 16'h5A5A, 1'b0, 16'h5A5A, 1'b0);
        cyc("load_0000",     1'b0, 1'b1, MODO_LOAD,      1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        cyc("down_wrap",     1'b0, 1'b1, MODO_DOWN,      1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
        cyc("load_0006",     1'b0, 1'b1, MODO_LOAD,      1'b1, 16'h0006, 1'b0, 16'h0006, 1'b0);
        cyc("down_0005",     1'b0, 1'b1, MODO_DOWN,      1'b1, 16'h0000, 1'b0, 16'h0005, 1'b0);
        cyc("switch_up",     1'b0, 1'b1, MODO_UP,        1'b1, 16'h0000, 1'b0, 16'h0006, 1'b0);
        cyc("rst_midload",   1'b1, 1'b1, MODO_LOAD,      1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b0);

        //    tag            rst   modo       d      q      rco_hi
        ccyc("c_reset",     1'b1, MODO_UP,   8'h00, 8'h00, 1'b0);
        ccyc("c_load_0f",   1'b0, MODO_LOAD, 8'h0F, 8'h0F, 1'b0);
        ccyc("c_carry",     1'b0, MODO_UP,   8'h00, 8'h10, 1'b0);
        ccyc("c_load_ff",   1'b0, MODO_LOAD, 8'hFF, 8'hFF, 1'b0);
        ccyc("c_wrap",      1'b0, MODO_UP,   8'h00, 8'h00, 1'b1);
        ccyc("c_after",     1'b0, MODO_UP,   8'h00, 8'h01, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/counter_n_bits.md
COUNTER_N_BITS -- requirements
Module: counter_n_bits

Interface
REQ-001 Parameter WIDTH, default 16, counter width in bits, legal range 4..32.
REQ-002 Parameter DEC_STEP, default 3, decrement for MODO=2'b10, legal range 1..2^WIDTH-1.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 ENB  input  1  count enable; 0 = hold.
REQ-006 MODO  input  2  mode: 00 up by 1, 01 down by 1, 10 down by DEC_STEP, 11 parallel load.
REQ-007 CI  input  1  carry-in / cascade enable for count modes; tie to 1 when standalone.
REQ-008 D  input  WIDTH  parallel load value.
REQ-009 Q  output  WIDTH  registered count value.
REQ-010 RCO  output  1  registered ripple-carry-out; 1-cycle pulse after a wrap.
REQ-011 TC  output  1  combinational terminal count (look-ahead carry) for synchronous cascading.

Function
REQ-012 Priority per rising edge SHALL be RESET > ENB=0 > MODO.
REQ-013 ENB=0 SHALL hold Q and drive RCO<=0; it SHALL NOT clear Q.
REQ-014 ENB=1, MODO=00, CI=1: Q<=Q+1 mod 2^WIDTH; RCO<=1 iff Q was all-ones, else 0.
REQ-015 ENB=1, MODO=01, CI=1: Q<=Q-1 mod 2^WIDTH; RCO<=1 iff Q was 0, else 0.
REQ-016 ENB=1, MODO=10, CI=1: Q<=Q-DEC_STEP mod 2^WIDTH; RCO<=1 iff Q<DEC_STEP (unsigned), else 0.
REQ-017 ENB=1, MODO in {00,01,10}, CI=0: Q held, RCO<=0.
REQ-018 ENB=1, MODO=11: Q<=D regardless of CI; RCO<=0.
REQ-019 TC = ENB & CI & ((MODO=00 & Q=all-ones) | (MODO=01 & Q=0) | (MODO=10 & Q<DEC_STEP)); TC=0 in MODO=11 and during RESET.
REQ-020 TC SHALL equal the value RCO takes on the next edge when RESET=0.
REQ-021 Arithmetic SHALL be unsigned, modulo 2^WIDTH; no saturation; DEC_STEP truncated to WIDTH bits.
REQ-022 MODO change mid-count SHALL take effect on the same edge; no pipeline latency; Q latency 1 cycle from inputs.
REQ-023 Cascade: stage k+1 CI driven from stage k TC, all on the same CLK, SHALL form a synchronous counter of summed width; no derived or gated clocks.

Reset
REQ-024 RESET=1 at an edge SHALL set Q=0, RCO=0, overriding ENB, MODO, CI and D.
REQ-025 RESET asserted mid-count or mid-load SHALL discard that operation; counting resumes from 0 on the first edge with RESET=0.
REQ-026 No initial blocks SHALL be relied on for state; Q and RCO are undefined only before the first reset edge.

Structure
REQ-027 Shared package counter_pkg SHALL hold the MODO encodings (MODO_UP, MODO_DOWN, MODO_DOWN_STEP, MODO_LOAD) and the default WIDTH/DEC_STEP constants.
REQ-028 Single module, single always block for Q/RCO plus combinational TC; no sub-module required.
REQ-029 Wide cascading SHALL be done by instantiating counter_n_bits and chaining TC->CI, not by internal sub-modules.

Verification (WIDTH=16, DEC_STEP=3 unless stated)
REQ-030 Reset mid-count: Q=0x1234 counting up, RESET=1 for one edge -> Q=0x0000, RCO=0; next edge Q=0x0001.
REQ-031 Up wrap: load 0xFFFE, MODO=00, CI=1 -> Q=0xFFFF with TC=1, then Q=0x0000 with RCO=1 for exactly one cycle, then RCO=0.
REQ-032 Step-down wrap: load 0x0002, MODO=10 -> TC=1, next Q=0xFFFF, RCO=1; from 0x0003 -> Q=0x0000, RCO=0.
REQ-033 Hold: ENB=0 at Q=0x00A5 for 5 cycles -> Q=0x00A5, RCO=0; CI=0 in MODO=01 -> Q held; MODO=11 with CI=0, D=0x5A5A -> Q=0x5A5A.
REQ-034 Cascade: two WIDTH=4 instances, low TC->high CI, combined 0x0F up -> 0x10 on one edge, high-stage RCO=0; combined 0xFF -> 0x00, high RCO=1.
REQ-035 Down: load 0x0000, MODO=01 -> Q=0xFFFF, RCO=1; MODO switched 01->00 at Q=0x0005 -> next Q=0x0006.
